// File: rtl/sto_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sto_read_sequencer
// Purpose  : Drives the real/imag sample memories with paired-lag reads for
//            timing-offset estimation. Optional macro: STO_SEQ_BACKPRESSURE_EN
// Revision : 1.0
// ============================================================================
module sto_read_sequencer #(
   parameter int ADDR_W    = 12,
   parameter int MEM_DEPTH = 5120
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] win_len,
   input  logic [ADDR_W-1:0] fft_len,
   input  logic [ADDR_W-1:0] num_cand,
`ifdef STO_SEQ_BACKPRESSURE_EN
   input  logic              smp_ready,
`endif
   output logic              mem_mode,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [ADDR_W-1:0] mem_offset,
   output logic              smp_valid,
   output logic              win_first,
   output logic              win_last,
   output logic [ADDR_W-1:0] cand_idx,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] c_one = ADDR_W'(1);
   // Highest address touched is base+num_cand+win_len+fft_len-2; compare sum
   // against MEM_DEPTH+1 so the subtraction can never underflow.
   localparam logic [ADDR_W+1:0] c_lim = (ADDR_W+2)'(MEM_DEPTH + 1);

   state_t            r_state, w_state_n;
   logic [ADDR_W-1:0] r_len, w_len_n;
   logic [ADDR_W-1:0] r_ncand, w_ncand_n;
   logic [ADDR_W-1:0] r_fft, w_fft_n;
   logic [ADDR_W-1:0] r_addr, w_addr_n;
   logic [ADDR_W-1:0] r_cstart, w_cstart_n;
   logic [ADDR_W-1:0] r_k, w_k_n;
   logic [ADDR_W-1:0] r_d, w_d_n;
   logic              r_valid, w_valid_n;
   logic              r_first, w_first_n;
   logic              r_last, w_last_n;
   logic [ADDR_W-1:0] r_cidx, w_cidx_n;
   logic              r_done, w_done_n;
   logic              r_err, w_err_n;

   logic [ADDR_W+1:0] w_sum;
   logic              w_bad;
   logic              w_k_last;
   logic              w_d_last;
   logic              w_stall;

`ifdef STO_SEQ_BACKPRESSURE_EN
   logic [ADDR_W-1:0] r_pres, w_pres_n;
   assign w_stall  = r_valid & ~smp_ready;
   // While stalled, re-read the presented pair so memory outputs stay put.
   assign mem_addr = w_stall ? r_pres : r_addr;
`else
   assign w_stall  = 1'b0;
   assign mem_addr = r_addr;
`endif

   assign w_sum = {2'b00, base_addr} + {2'b00, num_cand}
                + {2'b00, win_len}   + {2'b00, fft_len};
   assign w_bad = (win_len == '0) | (num_cand == '0) | (w_sum > c_lim);

   assign w_k_last = (r_k == r_len - c_one);
   assign w_d_last = (r_d == r_ncand - c_one);

   always_comb begin
      w_state_n  = r_state;
      w_len_n    = r_len;
      w_ncand_n  = r_ncand;
      w_fft_n    = r_fft;
      w_addr_n   = r_addr;
      w_cstart_n = r_cstart;
      w_k_n      = r_k;
      w_d_n      = r_d;
      w_valid_n  = 1'b0;
      w_first_n  = r_first;
      w_last_n   = r_last;
      w_cidx_n   = r_cidx;
      w_done_n   = 1'b0;
      w_err_n    = 1'b0;
`ifdef STO_SEQ_BACKPRESSURE_EN
      w_pres_n   = r_pres;
`endif
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (w_bad) begin
                  w_err_n = 1'b1;
               end else begin
                  w_len_n    = win_len;
                  w_ncand_n  = num_cand;
                  w_fft_n    = fft_len;
                  w_addr_n   = base_addr;
                  w_cstart_n = base_addr;
                  w_k_n      = '0;
                  w_d_n      = '0;
                  w_state_n  = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            w_valid_n = 1'b1;
            if (!w_stall) begin
               w_first_n = (r_k == '0);
               w_last_n  = w_k_last;
               w_cidx_n  = r_d;
`ifdef STO_SEQ_BACKPRESSURE_EN
               w_pres_n  = r_addr;
`endif
               // k runs fastest; each new candidate restarts one past the last one's base.
               if (w_k_last) begin
                  if (w_d_last) begin
                     w_state_n = ST_DRAIN;
                  end else begin
                     w_k_n      = '0;
                     w_d_n      = r_d + c_one;
                     w_cstart_n = r_cstart + c_one;
                     w_addr_n   = r_cstart + c_one;
                  end
               end else begin
                  w_k_n    = r_k + c_one;
                  w_addr_n = r_addr + c_one;
               end
            end
         end
         ST_DRAIN: begin
            if (w_stall) begin
               w_valid_n = 1'b1;
            end else begin
               w_done_n  = 1'b1;
               w_state_n = ST_IDLE;
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_len    <= '0;
         r_ncand  <= '0;
         r_fft    <= '0;
         r_addr   <= '0;
         r_cstart <= '0;
         r_k      <= '0;
         r_d      <= '0;
         r_valid  <= 1'b0;
         r_first  <= 1'b0;
         r_last   <= 1'b0;
         r_cidx   <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
`ifdef STO_SEQ_BACKPRESSURE_EN
         r_pres   <= '0;
`endif
      end else begin
         r_state  <= w_state_n;
         r_len    <= w_len_n;
         r_ncand  <= w_ncand_n;
         r_fft    <= w_fft_n;
         r_addr   <= w_addr_n;
         r_cstart <= w_cstart_n;
         r_k      <= w_k_n;
         r_d      <= w_d_n;
         r_valid  <= w_valid_n;
         r_first  <= w_first_n;
         r_last   <= w_last_n;
         r_cidx   <= w_cidx_n;
         r_done   <= w_done_n;
         r_err    <= w_err_n;
`ifdef STO_SEQ_BACKPRESSURE_EN
         r_pres   <= w_pres_n;
`endif
      end
   end

   assign busy       = (r_state != ST_IDLE);
   assign mem_mode   = busy;
   assign mem_offset = r_fft;
   assign smp_valid  = r_valid;
   assign win_first  = r_first;
   assign win_last   = r_last;
   assign cand_idx   = r_cidx;
   assign done       = r_done;
   assign cfg_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sto_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sto_read_sequencer
// Purpose  : Scoreboard bench for sto_read_sequencer with a 1-cycle memory model.
// Revision : 1.0
// ============================================================================
module tb_sto_read_sequencer;
   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] win_len = '0;
   logic [ADDR_W-1:0] fft_len = '0;
   logic [ADDR_W-1:0] num_cand = '0;
   logic              smp_ready = 1'b1;
   logic              mem_mode;
   logic [ADDR_W-1:0] mem_addr;
   logic [ADDR_W-1:0] mem_offset;
   logic              smp_valid;
   logic              win_first;
   logic              win_last;
   logic [ADDR_W-1:0] cand_idx;
   logic              busy;
   logic              done;
   logic              cfg_err;

   sto_read_sequencer #(.ADDR_W(ADDR_W), .MEM_DEPTH(5120)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .base_addr(base_addr), .win_len(win_len), .fft_len(fft_len), .num_cand(num_cand),
`ifdef STO_SEQ_BACKPRESSURE_EN
      .smp_ready(smp_ready),
`endif
      .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_offset(mem_offset),
      .smp_valid(smp_valid), .win_first(win_first), .win_last(win_last),
      .cand_idx(cand_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   // Registered dual-read memory whose sample value equals its address.
   logic [ADDR_W-1:0] out1;
   logic [ADDR_W+1:0] out2;
   always @(posedge clk) begin
      out1 <= mem_addr;
      out2 <= {2'b00, mem_addr} + {2'b00, mem_offset};
   end

   typedef struct {
      int a;
      int c;
      bit f;
      bit l;
      int fft;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (smp_valid && smp_ready) begin
         if (sb.size() == 0) begin
            check_val("extra_pair", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check_val("pair_out1", out1, mon_e.a);
            check_val("pair_out2", out2, mon_e.a + mon_e.fft);
            check_val("pair_mark", {win_first, win_last, cand_idx},
                      {mon_e.f, mon_e.l, ADDR_W'(mon_e.c)});
         end
      end
   end

   task automatic push_exp(input int b, input int l, input int f, input int nc);
      for (int d = 0; d < nc; d++)
         for (int k = 0; k < l; k++)
            sb.push_back('{a: b + d + k, c: d, f: (k == 0), l: (k == l - 1), fft: f});
   endtask

   // Called at a negedge; returns at the negedge of the cycle after start.
   task automatic launch(input int b, input int l, input int f, input int nc, input bit ok);
      start     = 1'b1;
      base_addr = ADDR_W'(b);
      win_len   = ADDR_W'(l);
      fft_len   = ADDR_W'(f);
      num_cand  = ADDR_W'(nc);
      if (ok) push_exp(b, l, f, nc);
      @(negedge clk);
      start = 1'b0;
      if (ok) begin
         check_val("s1_ctrl", {busy, mem_mode, cfg_err}, 3'b110);
         check_val("s1_addr", mem_addr, b);
         check_val("s1_off", mem_offset, f);
      end else begin
         check_val("cfg_err", {cfg_err, busy, mem_mode}, 3'b100);
         @(negedge clk);
         check_val("cfg_after", {cfg_err, busy, smp_valid}, 3'b000);
      end
   endtask

   task automatic wait_done(input int n0, input int n_exp, input string tag);
      int n;
      n = n0;
      while (!done && n < n_exp + 20) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_done_lat"}, n, n_exp);
      check_val({tag, "_idle"}, {busy, mem_mode}, 2'b00);
      check_val({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit saw_done;
      repeat (3) @(negedge clk);
      check_val("reset_outs", {busy, mem_mode, mem_addr, mem_offset, smp_valid, win_first,
                               win_last, cand_idx, done, cfg_err}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single candidate, 16 pairs.
      launch(0, 16, 64, 1, 1'b1);
      wait_done(1, 18, "t1");
      @(negedge clk);

      // Three overlapping candidates.
      launch(100, 4, 64, 3, 1'b1);
      wait_done(1, 14, "t2");
      @(negedge clk);

      // Range checks: one past the limit, zero length, zero candidates, then exactly at the limit.
      launch(4000, 1, 1024, 97, 1'b0);
      launch(0, 0, 64, 1, 1'b0);
      launch(0, 4, 64, 0, 1'b0);
      launch(4000, 1, 1024, 96, 1'b1);
      wait_done(1, 98, "edge");
      @(negedge clk);

      // Reset while the 5th pair is presented.
      launch(100, 4, 64, 3, 1'b1);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_val("rst_mid_outs", {busy, mem_mode, mem_addr, mem_offset, smp_valid, win_first,
                                 win_last, cand_idx, done, cfg_err}, 0);
      sb.delete();
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         saw_done |= done;
      end
      check_val("rst_no_done", saw_done, 1'b0);
      launch(0, 2, 8, 2, 1'b1);
      wait_done(1, 6, "post_rst");

      // Start while busy is ignored; start coincident with done is accepted.
      @(negedge clk);
      launch(0, 2, 8, 2, 1'b1);
      @(negedge clk);
      start = 1'b1;
      base_addr = 12'd500; win_len = 12'd3; fft_len = 12'd32; num_cand = 12'd5;
      @(negedge clk);
      start = 1'b0;
      check_val("ign_off", mem_offset, 8);
      wait_done(3, 6, "ign");
      launch(40, 3, 16, 2, 1'b1);
      wait_done(1, 8, "coin");

`ifdef STO_SEQ_BACKPRESSURE_EN
      // Stall three cycles on pair k=2 of candidate 0.
      @(negedge clk);
      launch(100, 4, 64, 3, 1'b1);
      repeat (3) @(negedge clk);
      smp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_val("bp_hold", {smp_valid, mem_addr, out1}, {1'b1, 12'd102, 12'd102});
         @(negedge clk);
      end
      smp_ready = 1'b1;
      wait_done(7, 17, "bp");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
